req_arbiter_4: RTL and testbench

- Four-requester arbiter that shares one downstream resource. It uses the team's 4-input priority-encoding scheme (input 3 highest) as its selection core.
- Adds registered one-hot grants, a selectable round-robin mode, grant hold until release, and a hold-timeout watchdog.
- Sits between the requesting masters and the shared datapath. Its `gnt_id` drives the datapath select.

---
 rtl/req_arbiter_4_pkg.sv | 33 +++
 rtl/req_arbiter_4_if.sv | 32 +++
 rtl/req_arbiter_4_rr_pick4.sv | 62 ++++++
 rtl/req_arbiter_4.sv | 136 +++++++++++++
 tb/tb_req_arbiter_4.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/req_arbiter_4_pkg.sv
// -----------------------------------------------------------------------------
// req_arbiter_4_pkg
// Shared definitions for the four-requester arbiter: requester count, FSM
// state encoding and the one-hot <-> 2-bit ID conversion helpers.
// -----------------------------------------------------------------------------
package req_arbiter_4_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // 2-bit requester ID to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [1:0] id);
        logic [NUM_REQ-1:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // One-hot grant vector to 2-bit requester ID (zero vector maps to 0).
    function automatic logic [1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/req_arbiter_4_if.sv
// -----------------------------------------------------------------------------
// req_arbiter_4_if
// Request/grant bundle between the requesting masters and the arbiter.
//   req[3:0]     request vector, req[3] highest fixed priority
//   rr_mode      1 = round-robin, 0 = fixed priority
//   gnt[3:0]     registered one-hot grant
//   gnt_id[1:0]  encoded owner index (0 when no grant)
//   gnt_valid    any grant active
//   timeout      one-cycle pulse on a forced release
// master: requester side, slave: arbiter side.
// -----------------------------------------------------------------------------
interface req_arbiter_4_if;
    import req_arbiter_4_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               rr_mode;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output req, rr_mode,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req, rr_mode,
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/req_arbiter_4_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational winner selection for four requesters.
//   req[3:0]      request vector
//   last_id[1:0]  previous winner (round-robin pointer)
//   rr_mode       1 = round-robin, 0 = fixed priority
//   win_id[1:0]   selected requester
//   win_valid     at least one request present
// Fixed mode picks the highest set index. Round-robin rotates the request
// vector so that index last_id+1 lands at bit 0, picks the lowest set bit and
// adds the rotation back, which gives the first requester after last_id.
// -----------------------------------------------------------------------------
module rr_pick4
    import req_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_id,
    input  logic               rr_mode,
    output logic [1:0]         win_id,
    output logic               win_valid
);

    // Highest set bit index; zero vector yields 0.
    function automatic logic [1:0] hi_enc(input logic [NUM_REQ-1:0] v);
        logic [1:0] id;
        casez (v)
            4'b1???: id = 2'd3;
            4'b01??: id = 2'd2;
            4'b001?: id = 2'd1;
            default: id = 2'd0;
        endcase
        return id;
    endfunction

    // Lowest set bit index; zero vector yields 3 (masked by win_valid).
    function automatic logic [1:0] lo_enc(input logic [NUM_REQ-1:0] v);
        logic [1:0] id;
        casez (v)
            4'b???1: id = 2'd0;
            4'b??10: id = 2'd1;
            4'b?100: id = 2'd2;
            default: id = 2'd3;
        endcase
        return id;
    endfunction

    logic [2:0]         shift_s;
    logic [7:0]         dbl_s;
    logic [NUM_REQ-1:0] rot_s;
    logic [1:0]         rr_id_s;

    // Rotated round-robin search and fixed-priority encode, then mode select.
    always_comb begin
        shift_s   = {1'b0, last_id} + 3'd1;
        dbl_s     = {req, req} >> shift_s;
        rot_s     = dbl_s[3:0];
        rr_id_s   = lo_enc(rot_s) + shift_s[1:0];
        win_id    = rr_mode ? rr_id_s : hi_enc(req);
        win_valid = |req;
    end

endmodule

// File: rtl/req_arbiter_4.sv
// -----------------------------------------------------------------------------
// req_arbiter_4
// Four-requester arbiter for one shared downstream resource.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    req_arbiter_4_if.slave (req, rr_mode in; gnt, gnt_id, gnt_valid,
//          timeout out)
// A grant is registered one cycle after requests are seen in IDLE and held
// until the owner drops its request or the hold watchdog (MAX_HOLD cycles,
// 0 = disabled) forces a release. Every release returns to IDLE, so there is
// always at least one cycle with no grant between two grants. Non-owner
// requests are ignored while a grant is active. CNT_W must satisfy
// 2^CNT_W > MAX_HOLD.
// -----------------------------------------------------------------------------
module req_arbiter_4
    import req_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    req_arbiter_4_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic             TO_EN      = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

    state_e             state_r, state_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [1:0]         gnt_id_r, gnt_id_nxt_s;
    logic               gnt_valid_r, gnt_valid_nxt_s;
    logic               timeout_r, timeout_nxt_s;
    logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;
    logic [1:0]         last_id_r, last_id_nxt_s;
    logic [1:0]         win_id_s;
    logic               win_valid_s;
    logic               owner_req_s;

    rr_pick4 u_pick (
        .req       (bus.req),
        .last_id   (last_id_r),
        .rr_mode   (bus.rr_mode),
        .win_id    (win_id_s),
        .win_valid (win_valid_s)
    );

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_nxt_s     = state_r;
        gnt_nxt_s       = gnt_r;
        gnt_id_nxt_s    = gnt_id_r;
        gnt_valid_nxt_s = gnt_valid_r;
        timeout_nxt_s   = 1'b0;
        hold_cnt_nxt_s  = hold_cnt_r;
        last_id_nxt_s   = last_id_r;
        owner_req_s     = bus.req[gnt_id_r];

        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    // rr_mode only matters here, so a change during GRANT
                    // naturally waits for the next arbitration.
                    gnt_nxt_s       = id_to_onehot(win_id_s);
                    gnt_id_nxt_s    = win_id_s;
                    gnt_valid_nxt_s = 1'b1;
                    hold_cnt_nxt_s  = CNT_ONE;
                    last_id_nxt_s   = win_id_s;
                    state_nxt_s     = ST_GRANT;
                end else begin
                    gnt_nxt_s       = 4'b0000;
                    gnt_id_nxt_s    = 2'd0;
                    gnt_valid_nxt_s = 1'b0;
                    hold_cnt_nxt_s  = {CNT_W{1'b0}};
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    // Voluntary release takes precedence over the watchdog.
                    gnt_nxt_s       = 4'b0000;
                    gnt_id_nxt_s    = 2'd0;
                    gnt_valid_nxt_s = 1'b0;
                    hold_cnt_nxt_s  = {CNT_W{1'b0}};
                    state_nxt_s     = ST_IDLE;
                end else if (TO_EN && (hold_cnt_r == MAX_HOLD_C)) begin
                    gnt_nxt_s       = 4'b0000;
                    gnt_id_nxt_s    = 2'd0;
                    gnt_valid_nxt_s = 1'b0;
                    hold_cnt_nxt_s  = {CNT_W{1'b0}};
                    timeout_nxt_s   = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    // Saturate so a disabled watchdog never wraps the count.
                    hold_cnt_nxt_s = (hold_cnt_r == CNT_SAT) ? hold_cnt_r
                                                             : hold_cnt_r + CNT_ONE;
                end
            end
            default: begin
                gnt_nxt_s       = 4'b0000;
                gnt_id_nxt_s    = 2'd0;
                gnt_valid_nxt_s = 1'b0;
                hold_cnt_nxt_s  = {CNT_W{1'b0}};
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State, counter, round-robin pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            hold_cnt_r  <= {CNT_W{1'b0}};
            last_id_r   <= 2'd2;
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= gnt_id_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            timeout_r   <= timeout_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            last_id_r   <= last_id_nxt_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_req_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_req_arbiter_4
// Bench for req_arbiter_4 (MAX_HOLD=4). A reference model steps once per
// rising edge from the arbitration rules (owner, cycles held, last winner)
// and queues the expected outputs; a monitor on the falling edge pops and
// compares. Directed sequences also check specific cycles explicitly, then
// randomized request bursts, mode flips and asynchronous resets follow.
// -----------------------------------------------------------------------------
module tb_req_arbiter_4;

    localparam int TB_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    req_arbiter_4_if bus ();

    req_arbiter_4 #(
        .MAX_HOLD (TB_MAX),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected {gnt[3:0], gnt_id[1:0], gnt_valid, timeout} per cycle.
    logic [7:0] exp_q[$];

    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 2;
    bit m_pulse = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
    endfunction

    // Reference model: one arbitration step per rising edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_held  = 0;
                m_last  = 2;
                m_pulse = 1'b0;
                exp_q.delete();
            end else begin
                int w;
                logic [7:0] e;
                m_pulse = 1'b0;
                if (m_owner < 0) begin
                    if (bus.req != 4'b0000) begin
                        w = -1;
                        if (bus.rr_mode) begin
                            for (int k = 1; k <= 4; k++)
                                if (w < 0 && bus.req[(m_last + k) % 4]) w = (m_last + k) % 4;
                        end else begin
                            for (int c = 3; c >= 0; c--)
                                if (w < 0 && bus.req[c]) w = c;
                        end
                        m_owner = w;
                        m_held  = 1;
                        m_last  = w;
                    end
                end else if (!bus.req[m_owner]) begin
                    m_owner = -1;
                    m_held  = 0;
                end else if (TB_MAX != 0 && m_held == TB_MAX) begin
                    m_owner = -1;
                    m_held  = 0;
                    m_pulse = 1'b1;
                end else begin
                    m_held++;
                end
                if (m_owner >= 0)
                    e = {4'(1 << m_owner), 2'(m_owner), 1'b1, m_pulse};
                else
                    e = {4'b0000, 2'b00, 1'b0, m_pulse};
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", dut_out(), 8'h00);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got %b expected queued entry at %0t", dut_out(), $time);
            end else begin
                chk("scoreboard", dut_out(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish within 400000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [3:0] r, input logic m);
        @(negedge clk);
        #1;
        bus.req     = r;
        bus.rr_mode = m;
    endtask

    // Check gnt/timeout just after the next rising edge.
    task automatic post(input string name, input logic [3:0] eg, input logic et);
        @(posedge clk);
        #1;
        chk(name, {3'b000, bus.gnt, bus.timeout}, {3'b000, eg, et});
    endtask

    task automatic async_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int order[5] = '{3, 0, 1, 2, 3};

    initial begin
        logic [3:0] r;
        logic       m;
        int         hold;

        bus.req     = 4'b0000;
        bus.rr_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_out(), 8'h00);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed priority with simultaneous requests, then release and next.
        drive(4'b0110, 1'b0);
        post("fixed_pick", 4'b0100, 1'b0);
        chk("fixed_pick_id", {6'd0, bus.gnt_id}, 8'd2);
        drive(4'b0010, 1'b0);
        post("fixed_release_gap", 4'b0000, 1'b0);
        post("fixed_next", 4'b0010, 1'b0);
        drive(4'b0000, 1'b0);
        post("fixed_done", 4'b0000, 1'b0);

        // Mode switch while requester 1 owns the grant.
        drive(4'b0010, 1'b0);
        post("ms_grant", 4'b0010, 1'b0);
        drive(4'b0010, 1'b1);
        post("ms_hold", 4'b0010, 1'b0);
        drive(4'b0001, 1'b1);
        post("ms_gap", 4'b0000, 1'b0);
        drive(4'b0011, 1'b1);
        post("ms_rr_from_2", 4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        post("ms_done", 4'b0000, 1'b0);

        // Hold-timeout watchdog.
        drive(4'b0001, 1'b0);
        for (int i = 0; i < TB_MAX; i++) post("to_held", 4'b0001, 1'b0);
        post("to_pulse", 4'b0000, 1'b1);
        post("to_regrant", 4'b0001, 1'b0);
        drive(4'b0000, 1'b0);
        post("to_done", 4'b0000, 1'b0);

        // No requests for 20 cycles.
        for (int i = 0; i < 20; i++) post("idle", 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a grant.
        drive(4'b1000, 1'b0);
        post("rst_pre_grant", 4'b1000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", dut_out(), 8'h00);
        drive(4'b1111, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        post("rr_first", 4'b1000, 1'b0);

        // Round-robin rotation, each owner drops its request after 3 cycles.
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(posedge clk);
            drive(4'b1111 & ~(4'b0001 << order[i]), 1'b1);
            post("rr_gap", 4'b0000, 1'b0);
            drive(4'b1111, 1'b1);
            post("rr_next", 4'(4'b0001 << order[i + 1]), 1'b0);
        end
        drive(4'b0000, 1'b1);
        post("rr_done", 4'b0000, 1'b0);

        // Randomized bursts checked by the scoreboard.
        m = 1'b0;
        for (int n = 0; n < 300; n++) begin
            r    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 7);
            if ($urandom_range(0, 3) == 0) m = ~m;
            for (int h = 0; h < hold; h++) begin
                drive(r, m);
                if ($urandom_range(0, 3) == 0) r = r & 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 49) == 0) async_pulse();
        end

        drive(4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
